// File: rtl/ddr_rd_burst_sched.sv
// AXI4 read-burst sequencer for one traffic-generator run: splits a byte-length
// transfer into INCR bursts that never cross 4KB and are issued only with FIFO credit.
module ddr_rd_burst_sched #(
  parameter int BEAT_BYTES      = 64,
  parameter int MAX_BURST       = 64,
  parameter int MAX_OUTSTANDING = 4,
  parameter int CREDIT_W        = 16
) (
  input  logic                ddr_clk,
  input  logic                rst,
  input  logic                cfg_start,
  input  logic [63:0]         cfg_base_addr,
  input  logic [63:0]         cfg_len_bytes,
  input  logic [CREDIT_W-1:0] fifo_free_beats,
  output logic                to_ddr_arvalid,
  input  logic                to_ddr_arready,
  output logic [63:0]         to_ddr_araddr,
  output logic [7:0]          to_ddr_arlen,
  output logic [1:0]          to_ddr_arburst,
  output logic [2:0]          to_ddr_arsize,
  input  logic                to_ddr_rvalid,
  input  logic                to_ddr_rready,
  input  logic                to_ddr_rlast,
  output logic                busy,
  output logic                done
);

  localparam int SIZE_LOG2   = $clog2(BEAT_BYTES);
  localparam int BOUND_BEATS = 4096 / BEAT_BYTES;
  localparam int OUT_W       = 4;
  localparam int BLEN_W      = 9;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALC,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [63:0]         addr_q, addr_d;
  logic [63:0]         beats_left_q, beats_left_d;
  logic [BLEN_W-1:0]   blen_q, blen_d;
  logic [7:0]          arlen_q, arlen_d;
  logic                arvalid_q, arvalid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [CREDIT_W-1:0] inflight_q, inflight_d;
  logic [OUT_W-1:0]    bursts_q, bursts_d;

  logic                ar_hs;
  logic                r_beat;
  logic                r_last;
  logic [63:0]         len_beats;
  logic [12:0]         to_bound;
  logic [12:0]         cand;
  logic [CREDIT_W:0]   credit_need;
  logic                credit_ok;
  logic [CREDIT_W:0]   infl_sum;
  logic [CREDIT_W:0]   infl_diff;
  logic [OUT_W:0]      burst_sum;
  logic [OUT_W:0]      burst_diff;

  assign ar_hs  = arvalid_q & to_ddr_arready;
  assign r_beat = to_ddr_rvalid & to_ddr_rready;
  assign r_last = r_beat & to_ddr_rlast;

  // Round the byte length up to whole beats.
  assign len_beats = (cfg_len_bytes >> SIZE_LOG2)
                   + 64'(|(cfg_len_bytes & 64'(BEAT_BYTES - 1)));

  assign to_bound = 13'(BOUND_BEATS) - 13'({1'b0, addr_q[11:0]} >> SIZE_LOG2);

  // One extra bit so that inflight + blen can never overflow the compare.
  assign credit_need = {1'b0, inflight_q} + (CREDIT_W+1)'(blen_q);
  assign credit_ok   = ({1'b0, fifo_free_beats} >= credit_need)
                    && (bursts_q < OUT_W'(MAX_OUTSTANDING));

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    beats_left_d = beats_left_q;
    blen_d       = blen_q;
    arlen_d      = arlen_q;
    arvalid_d    = arvalid_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    cand         = to_bound;

    case (state_q)
      S_IDLE: begin
        if (cfg_start && !busy_q) begin
          addr_d       = cfg_base_addr & ~64'(BEAT_BYTES - 1);
          beats_left_d = len_beats;
          busy_d       = 1'b1;
          state_d      = (len_beats == 64'd0) ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        if (13'(MAX_BURST) < cand) cand = 13'(MAX_BURST);
        if (beats_left_q < 64'(cand)) cand = 13'(beats_left_q);
        blen_d  = BLEN_W'(cand);
        arlen_d = 8'(cand - 13'd1);
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        // Once raised, arvalid holds with a stable address/length until accepted.
        if (ar_hs) begin
          arvalid_d    = 1'b0;
          addr_d       = addr_q + (64'(blen_q) << SIZE_LOG2);
          beats_left_d = beats_left_q - 64'(blen_q);
          state_d      = (beats_left_q != 64'(blen_q)) ? S_CALC : S_DRAIN;
        end else if (!arvalid_q && credit_ok) begin
          arvalid_d = 1'b1;
        end
      end
      S_DRAIN: begin
        if (bursts_q == '0 && inflight_q == '0) state_d = S_DONE;
      end
      S_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Net up/down counters, clamped at both ends so stray R beats cannot wrap them.
  always_comb begin
    infl_sum   = {1'b0, inflight_q} + (ar_hs ? (CREDIT_W+1)'(blen_q) : '0);
    infl_diff  = infl_sum - (CREDIT_W+1)'(r_beat);
    inflight_d = inflight_q;
    if (infl_sum < (CREDIT_W+1)'(r_beat)) inflight_d = '0;
    else if (infl_diff[CREDIT_W])         inflight_d = '1;
    else                                  inflight_d = infl_diff[CREDIT_W-1:0];

    burst_sum  = {1'b0, bursts_q} + (OUT_W+1)'(ar_hs);
    burst_diff = burst_sum - (OUT_W+1)'(r_last);
    bursts_d   = bursts_q;
    if (burst_sum < (OUT_W+1)'(r_last)) bursts_d = '0;
    else if (burst_diff[OUT_W])         bursts_d = '1;
    else                                bursts_d = burst_diff[OUT_W-1:0];
  end

  always_ff @(posedge ddr_clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      beats_left_q <= '0;
      blen_q       <= '0;
      arlen_q      <= '0;
      arvalid_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      inflight_q   <= '0;
      bursts_q     <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      beats_left_q <= beats_left_d;
      blen_q       <= blen_d;
      arlen_q      <= arlen_d;
      arvalid_q    <= arvalid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      inflight_q   <= inflight_d;
      bursts_q     <= bursts_d;
    end
  end

  assign to_ddr_arvalid = arvalid_q;
  assign to_ddr_araddr  = addr_q;
  assign to_ddr_arlen   = arlen_q;
  assign to_ddr_arburst = 2'b01;
  assign to_ddr_arsize  = 3'(SIZE_LOG2);
  assign busy           = busy_q;
  assign done           = done_q;

endmodule

// File: tb/tb_ddr_rd_burst_sched.sv
// Directed bench for ddr_rd_burst_sched: burst splitting, credit gating,
// outstanding limit, AR stability under backpressure and mid-run reset.
module tb_ddr_rd_burst_sched;

  logic        ddr_clk;
  logic        rst;
  logic        cfg_start;
  logic [63:0] cfg_base_addr;
  logic [63:0] cfg_len_bytes;
  logic [15:0] fifo_free_beats;
  logic        to_ddr_arvalid;
  logic        to_ddr_arready;
  logic [63:0] to_ddr_araddr;
  logic [7:0]  to_ddr_arlen;
  logic [1:0]  to_ddr_arburst;
  logic [2:0]  to_ddr_arsize;
  logic        to_ddr_rvalid;
  logic        to_ddr_rready;
  logic        to_ddr_rlast;
  logic        busy;
  logic        done;

  int errors = 0;
  int checks = 0;

  ddr_rd_burst_sched #(
    .BEAT_BYTES(64), .MAX_BURST(64), .MAX_OUTSTANDING(4), .CREDIT_W(16)
  ) dut (
    .ddr_clk         (ddr_clk),
    .rst             (rst),
    .cfg_start       (cfg_start),
    .cfg_base_addr   (cfg_base_addr),
    .cfg_len_bytes   (cfg_len_bytes),
    .fifo_free_beats (fifo_free_beats),
    .to_ddr_arvalid  (to_ddr_arvalid),
    .to_ddr_arready  (to_ddr_arready),
    .to_ddr_araddr   (to_ddr_araddr),
    .to_ddr_arlen    (to_ddr_arlen),
    .to_ddr_arburst  (to_ddr_arburst),
    .to_ddr_arsize   (to_ddr_arsize),
    .to_ddr_rvalid   (to_ddr_rvalid),
    .to_ddr_rready   (to_ddr_rready),
    .to_ddr_rlast    (to_ddr_rlast),
    .busy            (busy),
    .done            (done)
  );

  initial ddr_clk = 1'b0;
  always #5 ddr_clk = ~ddr_clk;

  // Observe and drive 1ns after the rising edge.
  task automatic tick();
    @(posedge ddr_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic start_run(input logic [63:0] base, input logic [63:0] len);
    cfg_base_addr = base;
    cfg_len_bytes = len;
    cfg_start     = 1'b1;
    tick();
    cfg_start     = 1'b0;
  endtask

  // Wait (bounded) for arvalid, check the request, then let the handshake edge pass.
  task automatic wait_ar(input string tag, input logic [63:0] exp_addr, input logic [7:0] exp_len);
    int n = 0;
    while (!to_ddr_arvalid && n < 100) begin
      tick();
      n++;
    end
    chk({tag, "_arvalid"}, to_ddr_arvalid, 1);
    chk({tag, "_araddr"}, to_ddr_araddr, exp_addr);
    chk({tag, "_arlen"}, to_ddr_arlen, exp_len);
    $display("AR %s addr=0x%0h arlen=%0d", tag, to_ddr_araddr, to_ddr_arlen);
    tick();
  endtask

  task automatic beats(input int n, input int per);
    for (int i = 1; i <= n; i++) begin
      to_ddr_rvalid = 1'b1;
      to_ddr_rready = 1'b1;
      to_ddr_rlast  = (i % per == 0);
      tick();
    end
    to_ddr_rvalid = 1'b0;
    to_ddr_rready = 1'b0;
    to_ddr_rlast  = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 200) begin
      tick();
      n++;
    end
    chk({tag, "_done"}, done, 1);
    chk({tag, "_busy_at_done"}, busy, 0);
    $display("DONE %s after %0d cycles", tag, n);
    tick();
    chk({tag, "_done_pulse"}, done, 0);
  endtask

  task automatic run_t1(input string tag);
    fifo_free_beats = 16'd512;
    to_ddr_arready  = 1'b1;
    start_run(64'h0, 64'd8192);
    chk({tag, "_busy_t1"}, busy, 1);
    chk({tag, "_arvalid_t1"}, to_ddr_arvalid, 0);
    tick();
    chk({tag, "_arvalid_t2"}, to_ddr_arvalid, 0);
    tick();
    wait_ar({tag, "_ar0"}, 64'h0, 8'd63);
    wait_ar({tag, "_ar1"}, 64'h1000, 8'd63);
    beats(128, 64);
    wait_done(tag);
  endtask

  initial begin
    rst             = 1'b1;
    cfg_start       = 1'b0;
    cfg_base_addr   = '0;
    cfg_len_bytes   = '0;
    fifo_free_beats = 16'd512;
    to_ddr_arready  = 1'b1;
    to_ddr_rvalid   = 1'b0;
    to_ddr_rready   = 1'b0;
    to_ddr_rlast    = 1'b0;
    repeat (3) tick();
    chk("rst_arvalid", to_ddr_arvalid, 0);
    chk("rst_araddr", to_ddr_araddr, 0);
    chk("rst_arlen", to_ddr_arlen, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("arburst", to_ddr_arburst, 2'b01);
    chk("arsize", to_ddr_arsize, 3'd6);
    rst = 1'b0;
    tick();

    // T1: two full 64-beat bursts
    run_t1("t1");

    // T2: 4KB split
    start_run(64'hFC0, 64'd256);
    wait_ar("t2_ar0", 64'hFC0, 8'd0);
    wait_ar("t2_ar1", 64'h1000, 8'd2);
    beats(1, 1);
    beats(3, 3);
    wait_done("t2");

    // T3: partial beat rounding, then zero length
    start_run(64'h2000, 64'd100);
    wait_ar("t3_ar0", 64'h2000, 8'd1);
    beats(2, 2);
    wait_done("t3");
    start_run(64'h3000, 64'd0);
    chk("t3z_busy_t1", busy, 1);
    chk("t3z_done_t1", done, 0);
    tick();
    chk("t3z_done_t2", done, 1);
    chk("t3z_busy_t2", busy, 0);
    chk("t3z_arvalid", to_ddr_arvalid, 0);
    tick();
    chk("t3z_done_t3", done, 0);

    // T4: credit gating and AR stability under backpressure
    fifo_free_beats = 16'd40;
    start_run(64'h0, 64'd4096);
    repeat (8) tick();
    chk("t4_nocredit", to_ddr_arvalid, 0);
    fifo_free_beats = 16'd64;
    to_ddr_arready  = 1'b0;
    tick();
    chk("t4_arvalid", to_ddr_arvalid, 1);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t4_hold_arvalid", to_ddr_arvalid, 1);
      chk("t4_hold_araddr", to_ddr_araddr, 64'h0);
      chk("t4_hold_arlen", to_ddr_arlen, 8'd63);
    end
    to_ddr_arready = 1'b1;
    tick();
    chk("t4_after_hs", to_ddr_arvalid, 0);
    beats(64, 64);
    wait_done("t4");

    // T5: outstanding limit
    fifo_free_beats = 16'd4096;
    start_run(64'h0, 64'd65536);
    wait_ar("t5_ar0", 64'h0000, 8'd63);
    wait_ar("t5_ar1", 64'h1000, 8'd63);
    wait_ar("t5_ar2", 64'h2000, 8'd63);
    wait_ar("t5_ar3", 64'h3000, 8'd63);
    repeat (10) tick();
    chk("t5_stall", to_ddr_arvalid, 0);
    beats(64, 64);
    wait_ar("t5_ar4", 64'h4000, 8'd63);

    // T6: reset mid-run after two ARs, stray beats, then a clean rerun
    rst = 1'b1;
    tick();
    rst = 1'b0;
    start_run(64'h0, 64'd65536);
    wait_ar("t6_ar0", 64'h0000, 8'd63);
    wait_ar("t6_ar1", 64'h1000, 8'd63);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_arvalid", to_ddr_arvalid, 0);
    chk("t6_busy", busy, 0);
    chk("t6_araddr", to_ddr_araddr, 0);
    chk("t6_inflight", 64'(dut.inflight_q), 0);
    chk("t6_bursts", 64'(dut.bursts_q), 0);
    beats(5, 2);
    chk("t6_stray_inflight", 64'(dut.inflight_q), 0);
    chk("t6_stray_bursts", 64'(dut.bursts_q), 0);
    run_t1("t6_t1");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
